stage_ex_divider: RTL
=====================

# stage_ex_divider

Multi-cycle iterative divider and its sequencing FSM for the EX stage. It runs DIV/DIVU (radix-2 restoring, one quotient bit per cycle) and raises a stall request so the pipeline holds the instruction in EX until the result is ready. The EX stage writes the quotient/remainder into HI/LO. On a pipeline flush, `annul` aborts the operation in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.

Ports (reset is synchronous and active-high; single clock):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: divide request. EX holds it high, with operands stable, until `ready` is seen.
- `annul` in 1: abort the current or requested division (flush).
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `opv1` in WIDTH: dividend.
- `opv2` in WIDTH: divisor.
- `ready` out 1: result valid. Registered.
- `stall_req` out 1: stall request to pipeline control. Combinational.
- `quot` out WIDTH: quotient, destined for LO. Registered.
- `rem` out WIDTH: remainder, destined for HI. Registered.

## Operation
States: IDLE, DIVZERO, ON, END.
- **IDLE:**
  - `start && !annul && opv2==0` -> DIVZERO.
  - `start && !annul` -> ON.
  - On entering ON: latch the magnitudes of the operands (absolute value when `signed_div`, else raw), latch the result signs, clear the iteration counter.
- **ON:**
  - Each cycle shift the {partial remainder, dividend} register left by 1 and trial-subtract the divisor.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Increment the counter. After WIDTH iterations -> END.
- **DIVZERO:** -> END with `quot`=0, `rem`=0.
- **END:**
  - `ready`=1 and `quot`/`rem` are driven.
  - The FSM stays in END while `start`=1. When `start`=0 it returns to IDLE, and `ready`, `quot`, and `rem` go to 0.
- **Sign correction (applied on entry to END):**
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives `quot`=0x80000000, `rem`=0 (wraps silently, no trap).
- **Annul:**
  - `annul`=1 in ON or DIVZERO -> IDLE on the next edge, with no `ready` pulse.
  - `annul` in END -> IDLE, and `ready` drops.
- **stall_req:**
  - stall_req = !annul && ((IDLE && start) || ON || DIVZERO).
  - It is 0 in END, so the pipeline advances on the `ready` cycle.
- **Sampling rule:** `start` is only sampled in IDLE. Operand changes during ON are ignored.

## Timing
- **Reset:** `rst`=1 at an edge -> IDLE; `ready`=0, `quot`=0, `rem`=0, counter=0. `stall_req`=0 while in reset. Reset mid-operation discards the division.
- **Normal divide:** `start` seen in IDLE at cycle T -> ON at T+1. Iterations run T+1..T+WIDTH. END/`ready`=1 at T+WIDTH+1 (T+33 for WIDTH=32).
- **Divide by zero:** `ready` at T+2.
- **Back-to-back divides:** require `start` to drop for at least one cycle. A new `start` is accepted at the earliest in the IDLE cycle after END.
- **Simultaneous `start` and `annul` in IDLE:** stay in IDLE, no stall.

## Configuration
- **Macro `DIV_EARLY_EXIT_EN`:**
  - **Defined:** in IDLE, if `start && !annul`, divisor ≠ 0, and |dividend| < |divisor| (magnitudes per `signed_div`), go directly to END. Result: `quot`=0, `rem`=`opv1` (original signed value), `ready` at T+1, and `stall_req` high only in cycle T.
  - **Undefined:** such operands take the full WIDTH-iteration path and give the identical result at T+WIDTH+1.

## Test plan
1. **DIVU:** 100 / 7 -> `quot`=14, `rem`=2. `ready` at T+33; `stall_req` high T..T+32, low at T+33.
2. **DIV signed:**
   - -7 / 2 -> `quot`=0xFFFFFFFD, `rem`=0xFFFFFFFF.
   - 0x80000000 / 0xFFFFFFFF -> `quot`=0x80000000, `rem`=0.
3. **Divide by zero:** 5 / 0 (both signednesses) -> `ready` at T+2, `quot`=0, `rem`=0. Hold `start` 3 extra cycles -> `ready` stays 1; drop `start` -> IDLE, outputs 0.
4. **Annul:** pulse `annul` at T+10 -> IDLE at T+11, `ready` never asserts, `stall_req` is 0 at T+10. A following 9 / 3 gives `quot`=3, `rem`=0 at 33 cycles.
5. **Reset mid-operation:** `rst` at T+5 -> all outputs 0 the next cycle. A subsequent 0xFFFFFFFF / 1 DIVU gives `quot`=0xFFFFFFFF, `rem`=0.
6. **Early exit:** DIVU 3 / 10 -> `quot`=0, `rem`=3. `ready` at T+1 with `DIV_EARLY_EXIT_EN`, at T+33 without.

Source files
------------

// File: rtl/stage_ex_divider_if.sv
// Handshake/operand bundle between the EX stage (master) and the iterative divider (slave).
interface stage_ex_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             annul;
    logic             signed_div;
    logic [WIDTH-1:0] opv1;
    logic [WIDTH-1:0] opv2;
    logic             ready;
    logic             stall_req;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output start, annul, signed_div, opv1, opv2,
        input  ready, stall_req, quot, rem
    );

    modport slave (
        input  start, annul, signed_div, opv1, opv2,
        output ready, stall_req, quot, rem
    );
endinterface

// File: rtl/stage_ex_divider.sv
// EX-stage radix-2 restoring divider (DIV/DIVU) with its sequencing FSM.
// One quotient bit per cycle, WIDTH iterations; stalls the pipeline while busy.
// Optional macro DIV_EARLY_EXIT_EN: when |dividend| < |divisor| the result
// (quot=0, rem=dividend) is produced directly from IDLE in one cycle.
module stage_ex_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    stage_ex_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial remainder, dividend/quotient}
    logic [WIDTH-1:0]   dsr_q, dsr_d;     // divisor magnitude
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    // Operand magnitudes, only meaningful while IDLE samples the request.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag1, mag2;
    assign a_neg = bus.signed_div & bus.opv1[WIDTH-1];
    assign b_neg = bus.signed_div & bus.opv2[WIDTH-1];
    assign mag1  = a_neg ? -bus.opv1 : bus.opv1;
    assign mag2  = b_neg ? -bus.opv2 : bus.opv2;

    // One restoring step: the shifted remainder needs WIDTH+1 bits because the
    // divisor magnitude may use all WIDTH bits.
    logic [WIDTH:0]     sh_hi;
    logic [WIDTH-1:0]   sub_lo;
    logic               take;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   fin_q, fin_r;
    assign sh_hi    = acc_q[2*WIDTH-1:WIDTH-1];
    assign take     = sh_hi >= {1'b0, dsr_q};
    assign sub_lo   = sh_hi[WIDTH-1:0] - dsr_q;
    assign step_acc = take ? {sub_lo, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};
    assign fin_q    = step_acc[WIDTH-1:0];
    assign fin_r    = step_acc[2*WIDTH-1:WIDTH];

    // Next-state and registered-output computation for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ready_d = ready_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                quot_d  = '0;
                rem_d   = '0;
                if (bus.start && !bus.annul) begin
                    if (bus.opv2 == '0) begin
                        state_d = S_DIVZERO;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (mag1 < mag2) begin
                        state_d = S_END;
                        ready_d = 1'b1;
                        quot_d  = '0;
                        rem_d   = bus.opv1;
                    end
`endif
                    else begin
                        state_d = S_ON;
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                        dsr_d   = mag2;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = '0;
                    end
                end
            end
            S_DIVZERO: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                    ready_d = 1'b1;
                    quot_d  = '0;
                    rem_d   = '0;
                end
            end
            S_ON: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Sign correction happens on the way into END.
                        state_d = S_END;
                        ready_d = 1'b1;
                        quot_d  = qneg_q ? -fin_q : fin_q;
                        rem_d   = rneg_q ? -fin_r : fin_r;
                    end
                end
            end
            S_END: begin
                if (bus.annul || !bus.start) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                    quot_d  = '0;
                    rem_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ready_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ready_q <= ready_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Stall is combinational so the request cycle itself already holds EX;
    // it is low in END so the pipeline advances on the ready cycle.
    assign bus.stall_req = !rst && !bus.annul &&
                           ((state_q == S_IDLE && bus.start) ||
                            state_q == S_ON || state_q == S_DIVZERO);
    assign bus.ready = ready_q;
    assign bus.quot  = quot_q;
    assign bus.rem   = rem_q;
endmodule
